// File: rtl/seg7_scan_if.sv
// Display-side bus for seg7_scan: load strobe, data, blanking control in;
// segment/anode drive and pending status out.
interface seg7_scan_if;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;

    // Host side: drives the value to show and watches the display outputs.
    modport master (
        output load, data_in, blank_lz,
        input  seg, an, pending
    );

    // Display controller side.
    modport slave (
        input  load, data_in, blank_lz,
        output seg, an, pending
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner. A prescaler paces the digit
// slots. New values land in a shadow register and are committed to the
// displayed copy only at the end of a full frame, so a frame is never torn.
// Optional leading-zero blanking is applied to the displayed copy.
module seg7_scan #(
    parameter int unsigned DIV            = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input logic         clk,
    input logic         reset_n,
    seg7_scan_if.slave  bus
);

    localparam int unsigned      CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [6:0]       SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Hex nibble to {g,f,e,d,c,b,a}, adjusted for the configured polarity.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] low;
        case (nib)
            4'h0: low = 7'h40;
            4'h1: low = 7'h79;
            4'h2: low = 7'h24;
            4'h3: low = 7'h30;
            4'h4: low = 7'h19;
            4'h5: low = 7'h12;
            4'h6: low = 7'h02;
            4'h7: low = 7'h78;
            4'h8: low = 7'h00;
            4'h9: low = 7'h10;
            4'hA: low = 7'h08;
            4'hB: low = 7'h03;
            4'hC: low = 7'h46;
            4'hD: low = 7'h21;
            4'hE: low = 7'h06;
            default: low = 7'h0E;
        endcase
        return SEG_ACTIVE_LOW ? low : ~low;
    endfunction

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       idx_q,     idx_d;
    logic [15:0]      shadow_q,  shadow_d;
    logic [15:0]      disp_q,    disp_d;
    logic             pending_q, pending_d;
    logic [6:0]       seg_q,     seg_d;
    logic [3:0]       an_q,      an_d;

    logic        tick;
    logic        commit;
    logic [15:0] upper;
    logic        blank_digit;

    // Next-state logic: prescaler, digit index, load/commit, output decode.
    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        tick   = (cnt_q == CNT_MAX);
        commit = tick && (idx_q == 2'd3);

        if (tick) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Commit takes the shadow as it was before this edge, even if a
        // load arrives in the same cycle.
        if (commit) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end

        // A load always wins over the commit's clear of pending.
        if (bus.load) begin
            shadow_d  = bus.data_in;
            pending_d = 1'b1;
        end

        // Nibbles idx..3 of the displayed value; all zero means a leading zero.
        upper       = disp_q >> {idx_q, 2'b00};
        blank_digit = bus.blank_lz && (idx_q != 2'd0) && (upper == 16'h0000);

        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank_digit ? SEG_OFF : decode(upper[3:0]);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= 4'b1111;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan. Two instances share clock, reset and
// stimulus: one with DIV=4 / active-low segments, one with DIV=1 /
// active-high segments. A cycle-level reference model derives the scan
// position arithmetically from the number of edges since reset.
module tb_seg7_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    seg7_scan_if bus_a ();
    seg7_scan_if bus_b ();

    seg7_scan #(.DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    seg7_scan #(.DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Active-low glyph table, indexed by hex value.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state, one slot per instance.
    int          m_n       [2];
    logic [15:0] m_shadow  [2];
    logic [15:0] m_disp    [2];
    logic        m_pending [2];
    logic [6:0]  m_seg     [2];
    logic [3:0]  m_an      [2];

    function automatic int div_of(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic bit active_low_of(int d);
        return (d == 0);
    endfunction

    // What digit k of value v should look like on the segments.
    function automatic logic [6:0] expect_seg(int d, logic [15:0] v, int k, logic blk);
        int         rest;
        logic [6:0] low;
        rest = int'(v) >> (4 * k);
        if (blk && k != 0 && rest == 0) low = 7'h7F;
        else                            low = glyph[rest % 16];
        return active_low_of(d) ? low : (~low & 7'h7F);
    endfunction

    // Advance model d across one rising edge with the given inputs.
    task automatic model_edge(int d, logic rst, logic ld, logic [15:0] data, logic blk);
        int          k;
        bit          is_tick, is_commit;
        logic [15:0] next_disp;
        if (!rst) begin
            m_n[d]       = 0;
            m_shadow[d]  = 16'h0;
            m_disp[d]    = 16'h0;
            m_pending[d] = 1'b0;
            m_an[d]      = 4'b1111;
            m_seg[d]     = active_low_of(d) ? 7'h7F : 7'h00;
        end else begin
            k         = (m_n[d] / div_of(d)) % 4;
            is_tick   = (m_n[d] % div_of(d)) == div_of(d) - 1;
            is_commit = is_tick && k == 3;
            m_an[d]   = 4'hF ^ 4'(1 << k);
            m_seg[d]  = expect_seg(d, m_disp[d], k, blk);
            next_disp = is_commit ? m_shadow[d] : m_disp[d];
            if (ld) begin
                m_shadow[d]  = data;
                m_pending[d] = 1'b1;
            end else if (is_commit) begin
                m_pending[d] = 1'b0;
            end
            m_disp[d] = next_disp;
            m_n[d]++;
        end
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, then compare.
    task automatic step(logic rst, logic ld, logic [15:0] data, logic blk);
        @(negedge clk);
        reset_n        = rst;
        bus_a.load     = ld;
        bus_a.data_in  = data;
        bus_a.blank_lz = blk;
        bus_b.load     = ld;
        bus_b.data_in  = data;
        bus_b.blank_lz = blk;
        @(posedge clk);
        model_edge(0, rst, ld, data, blk);
        model_edge(1, rst, ld, data, blk);
        #1;
        check("a_seg",     16'(bus_a.seg),     16'(m_seg[0]));
        check("a_an",      16'(bus_a.an),      16'(m_an[0]));
        check("a_pending", 16'(bus_a.pending), 16'(m_pending[0]));
        check("b_seg",     16'(bus_b.seg),     16'(m_seg[1]));
        check("b_an",      16'(bus_b.an),      16'(m_an[1]));
        check("b_pending", 16'(bus_b.pending), 16'(m_pending[1]));
    endtask

    task automatic idle(int cycles, logic blk);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 16'h0, blk);
    endtask

    logic blk_r;

    initial begin
        reset_n        = 1'b0;
        bus_a.load     = 1'b0;
        bus_a.data_in  = 16'h0;
        bus_a.blank_lz = 1'b0;
        bus_b.load     = 1'b0;
        bus_b.data_in  = 16'h0;
        bus_b.blank_lz = 1'b0;

        // Reset, with a load held at the same time that must be ignored.
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        // Release: outputs stay off for a cycle, then digit 0 shows "0".
        idle(3, 1'b0);

        // Load 1234h and watch it through several frames.
        step(1'b1, 1'b1, 16'h1234, 1'b0);
        idle(40, 1'b0);

        // Two loads in one frame: only the later value may ever show.
        step(1'b1, 1'b1, 16'hABCD, 1'b0);
        idle(1, 1'b0);
        step(1'b1, 1'b1, 16'h5678, 1'b0);
        idle(40, 1'b0);

        // Leading-zero blanking on, then off.
        step(1'b1, 1'b1, 16'h000F, 1'b1);
        idle(24, 1'b1);
        idle(24, 1'b0);
        step(1'b1, 1'b1, 16'h0A00, 1'b1);
        idle(24, 1'b1);

        // Load exactly on the commit edge.
        step(1'b1, 1'b1, 16'h4321, 1'b0);
        for (int i = 0; i < 20 && !((m_n[0] % 4) == 3 && ((m_n[0] / 4) % 4) == 3); i++)
            step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h9ABC, 1'b0);
        idle(36, 1'b0);

        // Mid-scan reset with a pending value.
        step(1'b1, 1'b1, 16'h7E57, 1'b0);
        idle(5, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        idle(20, 1'b0);

        // All-eights pattern (every segment lit after commit).
        step(1'b1, 1'b1, 16'h8888, 1'b0);
        idle(20, 1'b0);

        // Randomized traffic: sparse loads, blanking toggles, rare resets.
        blk_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(31) == 0) blk_r = ~blk_r;
            step(($urandom_range(99) != 0), ($urandom_range(7) == 0),
                 16'($urandom), blk_r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 50000, prescaler clock cycles per digit slot; legal range 1 to 2^20.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1; 1 = segment lit when its bit is 0, 0 = segment lit when its bit is 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-005 load  input  1  single-cycle strobe; capture data_in this cycle.
REQ-006 data_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-007 blank_lz  input  1  1 = blank leading-zero digits.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW, registered.
REQ-009 an  output  4  digit enables, active-low one-hot, an[k] = digit k, registered.
REQ-010 pending  output  1  high while a loaded value awaits frame commit.

Function
REQ-011 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where cnt == DIV-1; DIV=1 SHALL tick every cycle.
REQ-012 Digit index idx (2 bits) SHALL advance by 1 on each tick, wrapping 3 -> 0.
REQ-013 load=1 SHALL write data_in into shadow register and set pending=1 on the next edge; load while pending=1 SHALL overwrite shadow, keep pending=1, and discard the earlier value.
REQ-014 Frame commit SHALL occur on a tick with idx==3: disp <= shadow, pending <= 0 on that edge.
REQ-015 load coincident with a commit: disp SHALL take the shadow value held before that edge, shadow SHALL take data_in, pending SHALL remain 1.
REQ-016 Each cycle outside reset: an SHALL equal ~(4'b0001 << idx) and seg SHALL equal decode(disp nibble idx); outputs therefore lag idx/disp by exactly 1 cycle.
REQ-017 Active-low decode (gfedcba): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh; SEG_ACTIVE_LOW=0 SHALL output the bitwise inverse.
REQ-018 With blank_lz=1, digit k (k = 1..3) SHALL be blanked (all segments off) when disp nibbles k..3 are all zero; digit 0 SHALL never be blanked; an is unaffected by blanking.
REQ-019 Blanking SHALL evaluate against disp, never shadow; blank_lz change SHALL take effect on the next output update.
REQ-020 Data loaded mid-frame SHALL NOT appear on seg before the next commit (no torn frames).

Reset
REQ-021 reset_n=0 at a rising edge SHALL set cnt=0, idx=0, shadow=0, disp=0, pending=0, an=4'b1111, seg=all-off (7Fh if SEG_ACTIVE_LOW=1, 00h otherwise).
REQ-022 Reset SHALL override load in the same cycle; a pending value SHALL be lost.
REQ-023 First cycle after reset release: an SHALL remain 4'b1111 and seg SHALL remain all-off; the next edge SHALL drive an=4'b1110, seg=40h (digit 0 = "0"), blank_lz=0.

Verification (DIV=4, SEG_ACTIVE_LOW=1 unless stated)
REQ-024 Reset, then load data_in=1234h -> pending=1 until first idx==3 tick; thereafter an steps 1110,1101,1011,0111 every 4 cycles with seg 19h,30h,24h,79h.
REQ-025 Load ABCDh, then load 5678h 2 cycles later, same frame -> 5678h displayed after commit, ABCDh never appears on seg.
REQ-026 Load 000Fh with blank_lz=1 -> digit 0 seg=0Eh, digits 1-3 seg=7Fh with an still scanning; blank_lz=0 -> digits 1-3 seg=40h.
REQ-027 Load asserted on the commit edge -> old shadow committed, pending stays 1, new value committed one frame (16 cycles) later.
REQ-028 reset_n=0 for one cycle mid-scan with pending=1 -> an=1111, seg=7Fh, pending=0, idx restarts at 0, disp=0000h.
REQ-029 DIV=1, SEG_ACTIVE_LOW=0, load 8888h -> an changes every cycle, seg=7Fh on all digits after commit.
